test_pattern_gen_multi: RTL and testbench

Parametrised next-generation VGA test pattern generator for the video chain. It sits between the sync generator and the VGA output driver.
- Rebuilds column/row position from i_HSync/i_VSync with its own counters.
- Latches the pattern select only at frame start, so switching patterns never tears.
- Adds patterns beyond solid colours and checkerboard: colour bars, grey ramp, border, and a per-frame animated bouncing box.
- Provides a frame counter and a frame-start strobe.

---
 rtl/test_pattern_gen_multi.sv | 251 +++++++++++++++++++++++++
 tb/tb_test_pattern_gen_multi.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/test_pattern_gen_multi.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : test_pattern_gen_multi                                        |
// | Purpose  : VGA test pattern generator; rebuilds position from syncs and  |
// |            emits frame-aligned patterns. Macro TPG_MOVING_BOX_EN enables |
// |            the animated bouncing box (pattern 11).                       |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module test_pattern_gen_multi #(
  parameter int VIDEO_WIDTH = 3,
  parameter int TOTAL_COLS  = 800,
  parameter int TOTAL_ROWS  = 525,
  parameter int ACTIVE_COLS = 640,
  parameter int ACTIVE_ROWS = 480,
  parameter int COUNT_W     = 10,
  parameter int CHECK_LOG2  = 5,
  parameter int BOX_SIZE    = 32,
  parameter int BOX_STEP    = 4
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst,
  input  logic [3:0]             i_Pattern,
  input  logic                   i_HSync,
  input  logic                   i_VSync,
  output logic                   o_HSync,
  output logic                   o_VSync,
  output logic [VIDEO_WIDTH-1:0] o_Red_Video,
  output logic [VIDEO_WIDTH-1:0] o_Grn_Video,
  output logic [VIDEO_WIDTH-1:0] o_Blu_Video,
  output logic                   o_Frame_Start,
  output logic [7:0]             o_Frame_Count
);

  localparam logic [COUNT_W-1:0]     c_LAST_COL     = COUNT_W'(TOTAL_COLS - 1);
  localparam logic [COUNT_W-1:0]     c_LAST_ROW     = COUNT_W'(TOTAL_ROWS - 1);
  localparam logic [COUNT_W-1:0]     c_ACT_COLS     = COUNT_W'(ACTIVE_COLS);
  localparam logic [COUNT_W-1:0]     c_ACT_ROWS     = COUNT_W'(ACTIVE_ROWS);
  localparam logic [COUNT_W-1:0]     c_LAST_ACT_COL = COUNT_W'(ACTIVE_COLS - 1);
  localparam logic [COUNT_W-1:0]     c_LAST_ACT_ROW = COUNT_W'(ACTIVE_ROWS - 1);
  localparam int                     c_BAR_W        = ACTIVE_COLS / 8;
  localparam logic [COUNT_W-1:0]     c_BAR_LAST     = COUNT_W'(c_BAR_W - 1);
  localparam logic [VIDEO_WIDTH-1:0] c_FULL         = {VIDEO_WIDTH{1'b1}};

  logic               r_vsync;
  logic               r_hsync;
  logic [COUNT_W-1:0] r_col;
  logic [COUNT_W-1:0] r_row;
  logic [COUNT_W-1:0] r_bar_cnt;
  logic [2:0]         r_bar_idx;
  logic [3:0]         r_pattern;

  logic               w_vsync_rise;
  logic               w_col_wrap;
  logic               w_frame_start;
  logic [3:0]         w_pattern;
  logic               w_active;
  logic               w_on_border;
  logic [2:0]         w_bar_rgb;
  logic [VIDEO_WIDTH-1:0] w_red;
  logic [VIDEO_WIDTH-1:0] w_grn;
  logic [VIDEO_WIDTH-1:0] w_blu;

  assign w_vsync_rise  = i_VSync & ~r_vsync;
  assign w_col_wrap    = (r_col == c_LAST_COL);
  assign w_frame_start = (r_col == '0) && (r_row == '0);
  // The first pixel of a frame already uses the newly latched pattern.
  assign w_pattern     = w_frame_start ? i_Pattern : r_pattern;
  assign w_active      = (r_col < c_ACT_COLS) && (r_row < c_ACT_ROWS);
  assign w_on_border   = (r_col == '0) || (r_col == c_LAST_ACT_COL) ||
                         (r_row == '0) || (r_row == c_LAST_ACT_ROW);

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_vsync   <= 1'b0;
      r_hsync   <= 1'b0;
      r_col     <= '0;
      r_row     <= '0;
      r_bar_cnt <= '0;
      r_bar_idx <= 3'd0;
      r_pattern <= 4'd0;
    end else begin
      r_vsync <= i_VSync;
      r_hsync <= i_HSync;
      if (w_vsync_rise) begin
        r_col <= '0;
        r_row <= '0;
      end else if (w_col_wrap) begin
        r_col <= '0;
        r_row <= (r_row == c_LAST_ROW) ? '0 : r_row + COUNT_W'(1);
      end else begin
        r_col <= r_col + COUNT_W'(1);
      end
      // Bar index tracks the column without a divider; saturates on bar 7.
      if (w_vsync_rise || w_col_wrap) begin
        r_bar_cnt <= '0;
        r_bar_idx <= 3'd0;
      end else if (r_bar_cnt == c_BAR_LAST) begin
        r_bar_cnt <= '0;
        r_bar_idx <= (r_bar_idx == 3'd7) ? 3'd7 : r_bar_idx + 3'd1;
      end else begin
        r_bar_cnt <= r_bar_cnt + COUNT_W'(1);
      end
      if (w_frame_start) begin
        r_pattern <= i_Pattern;
      end
    end
  end

  always_comb begin
    w_bar_rgb = 3'b000;
    case (r_bar_idx)
      3'd0:    w_bar_rgb = 3'b111;
      3'd1:    w_bar_rgb = 3'b110;
      3'd2:    w_bar_rgb = 3'b011;
      3'd3:    w_bar_rgb = 3'b010;
      3'd4:    w_bar_rgb = 3'b101;
      3'd5:    w_bar_rgb = 3'b100;
      3'd6:    w_bar_rgb = 3'b001;
      default: w_bar_rgb = 3'b000;
    endcase
  end

`ifdef TPG_MOVING_BOX_EN
  localparam logic [COUNT_W:0] c_BOX   = (COUNT_W+1)'(BOX_SIZE);
  localparam logic [COUNT_W:0] c_STEP  = (COUNT_W+1)'(BOX_STEP);
  localparam logic [COUNT_W:0] c_REACH = (COUNT_W+1)'(BOX_SIZE + BOX_STEP);
  localparam logic [COUNT_W:0] c_X_LIM = (COUNT_W+1)'(ACTIVE_COLS);
  localparam logic [COUNT_W:0] c_Y_LIM = (COUNT_W+1)'(ACTIVE_ROWS);

  logic [COUNT_W-1:0] r_box_x;
  logic [COUNT_W-1:0] r_box_y;
  logic               r_box_x_neg;
  logic               r_box_y_neg;
  logic [COUNT_W:0]   w_box_x_nxt;
  logic [COUNT_W:0]   w_box_y_nxt;
  logic               w_box_tick;
  logic               w_in_box;

  // Returns {new_direction_negative, new_position} for one axis.
  function automatic logic [COUNT_W:0] f_axis_step(
    input logic [COUNT_W-1:0] pos,
    input logic               neg,
    input logic [COUNT_W:0]   lim
  );
    logic [COUNT_W:0] ext;
    ext = {1'b0, pos};
    if (!neg) begin
      if (ext + c_REACH > lim) f_axis_step = {1'b1, COUNT_W'(lim - c_BOX)};
      else                     f_axis_step = {1'b0, COUNT_W'(ext + c_STEP)};
    end else begin
      if (ext < c_STEP)        f_axis_step = {1'b0, {COUNT_W{1'b0}}};
      else                     f_axis_step = {1'b1, COUNT_W'(ext - c_STEP)};
    end
  endfunction

  assign w_box_tick  = (r_col == '0) && (r_row == c_ACT_ROWS);
  assign w_box_x_nxt = f_axis_step(r_box_x, r_box_x_neg, c_X_LIM);
  assign w_box_y_nxt = f_axis_step(r_box_y, r_box_y_neg, c_Y_LIM);
  assign w_in_box    = ({1'b0, r_col} >= {1'b0, r_box_x}) &&
                       ({1'b0, r_col} <  ({1'b0, r_box_x} + c_BOX)) &&
                       ({1'b0, r_row} >= {1'b0, r_box_y}) &&
                       ({1'b0, r_row} <  ({1'b0, r_box_y} + c_BOX));

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_box_x     <= '0;
      r_box_y     <= '0;
      r_box_x_neg <= 1'b0;
      r_box_y_neg <= 1'b0;
    end else if (w_box_tick) begin
      {r_box_x_neg, r_box_x} <= w_box_x_nxt;
      {r_box_y_neg, r_box_y} <= w_box_y_nxt;
    end
  end
`endif

  always_comb begin
    w_red = '0;
    w_grn = '0;
    w_blu = '0;
    if (w_active) begin
      case (w_pattern)
        4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7: begin
          w_red = {VIDEO_WIDTH{w_pattern[0]}};
          w_grn = {VIDEO_WIDTH{w_pattern[1]}};
          w_blu = {VIDEO_WIDTH{w_pattern[2]}};
        end
        4'd8: begin
          if (r_col[CHECK_LOG2] ^ r_row[CHECK_LOG2]) begin
            w_red = c_FULL;
            w_grn = c_FULL;
            w_blu = c_FULL;
          end
        end
        4'd9: begin
          w_red = {VIDEO_WIDTH{w_bar_rgb[2]}};
          w_grn = {VIDEO_WIDTH{w_bar_rgb[1]}};
          w_blu = {VIDEO_WIDTH{w_bar_rgb[0]}};
        end
        4'd10: begin
          w_red = r_col[COUNT_W-1 -: VIDEO_WIDTH];
          w_grn = r_col[COUNT_W-1 -: VIDEO_WIDTH];
          w_blu = r_col[COUNT_W-1 -: VIDEO_WIDTH];
        end
`ifdef TPG_MOVING_BOX_EN
        4'd11: begin
          w_red = w_in_box ? c_FULL : '0;
          w_grn = w_in_box ? c_FULL : '0;
          w_blu = c_FULL;
        end
`endif
        4'd12: begin
          if (w_on_border) begin
            w_red = c_FULL;
            w_grn = c_FULL;
            w_blu = c_FULL;
          end
        end
        default: begin
          w_red = '0;
          w_grn = '0;
          w_blu = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      o_HSync       <= 1'b0;
      o_VSync       <= 1'b0;
      o_Red_Video   <= '0;
      o_Grn_Video   <= '0;
      o_Blu_Video   <= '0;
      o_Frame_Start <= 1'b0;
      o_Frame_Count <= 8'd0;
    end else begin
      o_HSync       <= r_hsync;
      o_VSync       <= r_vsync;
      o_Red_Video   <= w_red;
      o_Grn_Video   <= w_grn;
      o_Blu_Video   <= w_blu;
      o_Frame_Start <= w_frame_start;
      if (w_frame_start) begin
        o_Frame_Count <= o_Frame_Count + 8'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_test_pattern_gen_multi.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_test_pattern_gen_multi                                     |
// | Purpose  : Randomised scoreboard bench for test_pattern_gen_multi using a |
// |            small raster so many frames fit in a short run.               |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_test_pattern_gen_multi;

  localparam int VW    = 3;
  localparam int TC    = 44;
  localparam int TR    = 28;
  localparam int AC    = 36;
  localparam int AR    = 24;
  localparam int CW    = 6;
  localparam int CL    = 2;
  localparam int BS    = 8;
  localparam int BST   = 3;
  localparam int FRAME = TC * TR;
  localparam int BAR_W = AC / 8;
  localparam int NCYC  = 50000;

  bit clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [3:0]    pat;
  logic          hs;
  logic          vs;
  logic          o_hs;
  logic          o_vs;
  logic [VW-1:0] o_r;
  logic [VW-1:0] o_g;
  logic [VW-1:0] o_b;
  logic          o_fs;
  logic [7:0]    o_fc;

  test_pattern_gen_multi #(
    .VIDEO_WIDTH(VW), .TOTAL_COLS(TC), .TOTAL_ROWS(TR),
    .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR), .COUNT_W(CW),
    .CHECK_LOG2(CL), .BOX_SIZE(BS), .BOX_STEP(BST)
  ) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Pattern(pat), .i_HSync(hs), .i_VSync(vs),
    .o_HSync(o_hs), .o_VSync(o_vs), .o_Red_Video(o_r), .o_Grn_Video(o_g),
    .o_Blu_Video(o_b), .o_Frame_Start(o_fs), .o_Frame_Count(o_fc)
  );

  // Packed expectation: {frame_start, frame_count[7:0], hsync, vsync, r, g, b}
  logic [19:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  // Reference state: stage-1 position, delayed syncs, latched pattern, box.
  int m_col, m_row, m_rv, m_hs1, m_pat, m_fc;
  int m_bx, m_by, m_bxneg, m_byneg;

  function automatic logic [8:0] pix(int p, int c, int r, int bx, int by);
    logic [2:0] bars [8];
    logic [2:0] g;
    int idx;
    bars = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};
    if (c >= AC || r >= AR) return 9'd0;
    if (p >= 1 && p <= 7)
      return {((p & 1) != 0) ? 3'd7 : 3'd0, ((p & 2) != 0) ? 3'd7 : 3'd0, ((p & 4) != 0) ? 3'd7 : 3'd0};
    if (p == 8) return ((((c >> CL) ^ (r >> CL)) & 1) != 0) ? 9'h1FF : 9'd0;
    if (p == 9) begin
      idx = c / BAR_W;
      if (idx > 7) idx = 7;
      return {{3{bars[idx][2]}}, {3{bars[idx][1]}}, {3{bars[idx][0]}}};
    end
    if (p == 10) begin
      g = 3'((c >> (CW - VW)) & 7);
      return {g, g, g};
    end
`ifdef TPG_MOVING_BOX_EN
    if (p == 11)
      return (c >= bx && c < bx + BS && r >= by && r < by + BS) ? 9'h1FF : 9'h007;
`endif
    if (p == 12) return (c == 0 || c == AC - 1 || r == 0 || r == AR - 1) ? 9'h1FF : 9'd0;
    return 9'd0;
  endfunction

  // Predicts the outputs produced by the coming clock edge and advances the model.
  task automatic model_edge();
    int p;
    logic fs;
    logic [8:0] rgb;
    if (rst) begin
      exp_q.push_back(20'd0);
      m_col = 0; m_row = 0; m_rv = 0; m_hs1 = 0; m_pat = 0; m_fc = 0;
      m_bx = 0; m_by = 0; m_bxneg = 0; m_byneg = 0;
      return;
    end
    fs = (m_col == 0 && m_row == 0);
    p  = fs ? int'(pat) : m_pat;
    if (fs) begin
      m_pat = int'(pat);
      m_fc  = (m_fc + 1) % 256;
    end
    rgb = pix(p, m_col, m_row, m_bx, m_by);
    exp_q.push_back({fs, 8'(m_fc), m_hs1[0], m_rv[0], rgb});
    if (m_col == 0 && m_row == AR) begin
      if (m_bxneg == 0) begin
        if (m_bx + BS + BST > AC) begin m_bx = AC - BS; m_bxneg = 1; end
        else m_bx = m_bx + BST;
      end else begin
        if (m_bx < BST) begin m_bx = 0; m_bxneg = 0; end
        else m_bx = m_bx - BST;
      end
      if (m_byneg == 0) begin
        if (m_by + BS + BST > AR) begin m_by = AR - BS; m_byneg = 1; end
        else m_by = m_by + BST;
      end else begin
        if (m_by < BST) begin m_by = 0; m_byneg = 0; end
        else m_by = m_by - BST;
      end
    end
    if (vs && m_rv == 0) begin
      m_col = 0;
      m_row = 0;
    end else begin
      m_col = m_col + 1;
      if (m_col == TC) begin
        m_col = 0;
        m_row = (m_row + 1) % TR;
      end
    end
    m_rv  = int'(vs);
    m_hs1 = int'(hs);
  endtask

  initial begin : monitor
    logic [19:0] e;
    logic [19:0] a;
    int cyc;
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {o_fs, o_fc, o_hs, o_vs, o_r, o_g, o_b};
        n_checks++;
        if (a !== e) begin
          n_errors++;
          $display("FAIL cyc=%0d outputs: got fs=%0b fc=%0d hs=%0b vs=%0b rgb=%0d,%0d,%0d expected fs=%0b fc=%0d hs=%0b vs=%0b rgb=%0d,%0d,%0d",
                   cyc, a[19], a[18:11], a[10], a[9], a[8:6], a[5:3], a[2:0],
                   e[19], e[18:11], e[10], e[9], e[8:6], e[5:3], e[2:0]);
        end
      end
    end
  end

  initial begin : stimulus
    int g;
    int fidx;
    int fpos;
    g   = FRAME - 300;
    rst = 1'b1;
    pat = 4'd0;
    hs  = 1'b0;
    vs  = 1'b0;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      rst  = (cyc < 3) || (cyc >= 20 * FRAME + 600 && cyc < 20 * FRAME + 603);
      hs   = 1'($urandom);
      vs   = ((g % FRAME) < 2 * TC);
      fidx = g / FRAME;
      fpos = g % FRAME;
      if (fidx < 16) begin
        // Walk every pattern, then disturb the request mid-frame.
        if (fpos == 0)           pat = 4'(fidx);
        else if (fpos == 5 * TC) pat = 4'(fidx + 1);
      end else if ($urandom_range(0, 399) == 0) begin
        pat = ($urandom_range(0, 1) == 0) ? 4'd11 : 4'($urandom_range(0, 15));
      end
      model_edge();
      @(posedge clk);
      #2;
      g++;
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
